// File: rtl/axis_segment_remover.sv
// AXI-Stream segment remover: strips S bytes at a fixed offset from every packet,
// re-packs the remaining bytes into full beats and reports the removed bytes on a sideband.
module axis_segment_remover #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int REMOVE_SIZE_BYTES = 4,
  parameter int REMOVE_OFFSET     = 12
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]      s_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]    s_tkeep,
  input  logic                           s_tlast,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  output logic [AXIS_BUS_WIDTH-1:0]      m_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]    m_tkeep,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [REMOVE_SIZE_BYTES*8-1:0] seg_data,
  output logic                           seg_valid,
  output logic                           short_pkt
);

  localparam int W        = AXIS_BUS_WIDTH;
  localparam int B        = W / 8;
  localparam int S        = REMOVE_SIZE_BYTES;
  localparam int HB       = B - S;
  localparam int P        = REMOVE_OFFSET % B;
  localparam int SEG_BEAT = REMOVE_OFFSET / B;
  localparam int NW       = $clog2(B + 1);
  localparam int CNT_W    = (SEG_BEAT > 1) ? $clog2(SEG_BEAT) : 1;

  typedef enum logic [1:0] {ST_HEAD, ST_SEG, ST_BODY, ST_DRAIN} state_t;

  // A segment in beat 0 means every packet starts directly in SEG.
  localparam state_t START_STATE = state_t'((SEG_BEAT == 0) ? ST_SEG : ST_HEAD);

  function automatic logic [NW-1:0] count_ones(input logic [B-1:0] k);
    logic [NW-1:0] n;
    n = '0;
    for (int i = 0; i < B; i++) n = n + NW'(k[i]);
    return n;
  endfunction

  function automatic logic [B-1:0] low_keep(input logic [NW-1:0] n);
    logic [B-1:0] k;
    k = '0;
    for (int i = 0; i < B; i++) if (i < int'(n)) k[i] = 1'b1;
    return k;
  endfunction

  function automatic logic [W-1:0] byte_mask(input logic [B-1:0] k);
    logic [W-1:0] m;
    for (int i = 0; i < B; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t              state, state_n;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_n;
  logic [HB*8-1:0]     hold, hold_n, compact;
  logic [NW-1:0]       drain_bytes, drain_bytes_n, in_n;
  logic                load, accept;
  logic                out_valid, out_last, seg_upd, short_upd;
  logic [W-1:0]        out_raw, out_data, body_word;
  logic [B-1:0]        out_keep;

  assign load      = m_tready || !m_tvalid;
  assign s_tready  = aresetn && load && (state != ST_DRAIN);
  assign accept    = s_tvalid && s_tready;
  assign in_n      = count_ones(s_tkeep);
  assign body_word = {s_tdata[S*8-1:0], hold};
  assign out_data  = out_raw & byte_mask(out_keep);

  // Segment beat with the S removed bytes squeezed out: bytes [0,P) then [P+S,B).
  always_comb begin
    compact = '0;
    for (int i = 0; i < HB; i++)
      compact[i*8 +: 8] = (i < P) ? s_tdata[i*8 +: 8] : s_tdata[(i+S)*8 +: 8];
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_n       = state;
    beat_cnt_n    = beat_cnt;
    hold_n        = hold;
    drain_bytes_n = drain_bytes;
    out_valid     = 1'b0;
    out_raw       = '0;
    out_keep      = '0;
    out_last      = 1'b0;
    seg_upd       = 1'b0;
    short_upd     = 1'b0;

    case (state)
      ST_HEAD: begin
        if (accept) begin
          out_valid = 1'b1;
          out_raw   = s_tdata;
          out_keep  = s_tkeep;
          out_last  = s_tlast;
          if (s_tlast) begin
            short_upd  = 1'b1;
            beat_cnt_n = '0;
          end else if (int'(beat_cnt) + 1 == SEG_BEAT) begin
            beat_cnt_n = '0;
            state_n    = ST_SEG;
          end else begin
            beat_cnt_n = beat_cnt + CNT_W'(1);
          end
        end
      end

      ST_SEG: begin
        if (accept) begin
          if (s_tlast && (int'(in_n) < P + S)) begin
            out_valid = 1'b1;
            out_raw   = s_tdata;
            out_keep  = s_tkeep;
            out_last  = 1'b1;
            short_upd = 1'b1;
            state_n   = START_STATE;
          end else begin
            seg_upd = 1'b1;
            if (!s_tlast) begin
              hold_n  = compact;
              state_n = ST_BODY;
            end else begin
              out_valid = 1'b1;
              out_raw   = {{(S*8){1'b0}}, compact};
              out_keep  = low_keep(in_n - NW'(S));
              out_last  = 1'b1;
              state_n   = START_STATE;
            end
          end
        end
      end

      ST_BODY: begin
        if (accept) begin
          out_valid = 1'b1;
          out_raw   = body_word;
          out_keep  = '1;
          hold_n    = s_tdata[W-1:S*8];
          if (s_tlast) begin
            if (int'(in_n) <= S) begin
              out_keep = low_keep(NW'(HB) + in_n);
              out_last = 1'b1;
              state_n  = START_STATE;
            end else begin
              drain_bytes_n = in_n - NW'(S);
              state_n       = ST_DRAIN;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (load) begin
          out_valid = 1'b1;
          out_raw   = {{(S*8){1'b0}}, hold};
          out_keep  = low_keep(drain_bytes);
          out_last  = 1'b1;
          state_n   = START_STATE;
        end
      end

      default: state_n = START_STATE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: hold is a single register, not a memory, so clearing it in reset is cheap.
      state       <= START_STATE;
      beat_cnt    <= '0;
      hold        <= '0;
      drain_bytes <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tdata     <= '0;
      m_tkeep     <= '0;
      seg_data    <= '0;
      seg_valid   <= 1'b0;
      short_pkt   <= 1'b0;
    end else begin
      state       <= state_n;
      beat_cnt    <= beat_cnt_n;
      hold        <= hold_n;
      drain_bytes <= drain_bytes_n;
      seg_valid   <= seg_upd;
      short_pkt   <= short_upd;
      if (seg_upd) seg_data <= s_tdata[P*8 +: S*8];
      // Output beat only moves when the downstream can take it, keeping m_* stable on stall.
      if (load) begin
        m_tvalid <= out_valid;
        if (out_valid) begin
          m_tdata <= out_data;
          m_tkeep <= out_keep;
          m_tlast <= out_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_segment_remover.sv
// Directed vector table plus reset, stall and random back-to-back scenarios for
// axis_segment_remover (B=8, S=4, offset 12), checked against a byte-level removal model.
module tb_axis_segment_remover;

  localparam int W   = 64;
  localparam int B   = 8;
  localparam int S   = 4;
  localparam int OFF = 12;

  typedef logic [7:0] u8_t;

  typedef struct {
    int        len;
    int        beats;
    logic [7:0] last_keep;
    int        segs;
    int        shorts;
    int        drains;
  } vec_t;

  logic           aclk, aresetn;
  logic [W-1:0]   s_tdata;
  logic [B-1:0]   s_tkeep;
  logic           s_tlast, s_tvalid, s_tready;
  logic [W-1:0]   m_tdata;
  logic [B-1:0]   m_tkeep;
  logic           m_tlast, m_tvalid, m_tready;
  logic [S*8-1:0] seg_data;
  logic           seg_valid, short_pkt;

  axis_segment_remover #(
    .AXIS_BUS_WIDTH(W), .REMOVE_SIZE_BYTES(S), .REMOVE_OFFSET(OFF)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .seg_data(seg_data), .seg_valid(seg_valid), .short_pkt(short_pkt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected model state, filled by push_expect and drained by the monitor.
  u8_t            exp_q[$];
  int             exp_len_q[$];
  logic [S*8-1:0] exp_seg_q[$];

  // Monitor state.
  u8_t        cur[$];
  int         beats, seg_cnt, short_cnt, rdy_low;
  logic [7:0] last_keep;
  bit         win, zero_bad, keep_bad, prev_stall, prev_last;
  logic [W-1:0] prev_data;
  logic [B-1:0] prev_keep;
  int         ready_mode = 0;

  always begin
    @(posedge aclk);
    #1;
    case (ready_mode)
      1:       m_tready = ($urandom_range(3) != 0);
      2:       m_tready = 1'b0;
      default: m_tready = 1'b1;
    endcase
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      cur.delete();
      prev_stall = 1'b0;
      zero_bad   = 1'b0;
      keep_bad   = 1'b0;
    end else begin
      if (win && !s_tready) rdy_low++;
      if (short_pkt) short_cnt++;
      if (seg_valid) begin
        seg_cnt++;
        if (exp_seg_q.size() == 0) check("seg_unexpected", 1, 0);
        else check("seg_data", seg_data, exp_seg_q.pop_front());
      end
      if (prev_stall) begin
        check("stall_data", m_tdata, prev_data);
        check("stall_ctl", {m_tvalid, m_tlast, m_tkeep}, {1'b1, prev_last, prev_keep});
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_keep  = m_tkeep;
      prev_last  = m_tlast;
      if (m_tvalid && m_tready) begin
        beats++;
        for (int i = 0; i < B; i++) begin
          if (m_tkeep[i]) cur.push_back(m_tdata[i*8 +: 8]);
          else if (m_tdata[i*8 +: 8] != 8'h00) zero_bad = 1'b1;
        end
        if (!m_tlast && m_tkeep != 8'hFF) keep_bad = 1'b1;
        if (m_tlast) begin
          last_keep = m_tkeep;
          if (exp_len_q.size() == 0) begin
            check("pkt_unexpected", 1, 0);
          end else begin
            int  len;
            int  nbad;
            u8_t e;
            len  = exp_len_q.pop_front();
            nbad = (cur.size() != len) ? 1 : 0;
            for (int i = 0; i < len; i++) begin
              e = exp_q.pop_front();
              if (i >= cur.size() || cur[i] !== e) nbad++;
            end
            nbad += int'(zero_bad) + int'(keep_bad);
            check("pkt_bytes", nbad, 0);
          end
          cur.delete();
          zero_bad = 1'b0;
          keep_bad = 1'b0;
        end
      end
    end
  end

  // Byte-level reference: drop bytes [OFF, OFF+S) when the packet holds them all.
  task automatic push_expect(input u8_t pkt[$]);
    logic [S*8-1:0] seg;
    if (pkt.size() >= OFF + S) begin
      for (int k = 0; k < S; k++) seg[k*8 +: 8] = pkt[OFF+k];
      exp_seg_q.push_back(seg);
      for (int i = 0; i < pkt.size(); i++)
        if (i < OFF || i >= OFF + S) exp_q.push_back(pkt[i]);
      exp_len_q.push_back(pkt.size() - S);
    end else begin
      for (int i = 0; i < pkt.size(); i++) exp_q.push_back(pkt[i]);
      exp_len_q.push_back(pkt.size());
    end
  endtask

  // Called and returns at posedge+1; each beat is held until sampled with s_tready high.
  task automatic send_pkt(input u8_t pkt[$], input int gap_pct, input bit close);
    int nb;
    bit acc;
    int t;
    nb = (pkt.size() + B - 1) / B;
    for (int bi = 0; bi < nb; bi++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
      end
      s_tdata = '0;
      s_tkeep = '0;
      for (int j = 0; j < B; j++) begin
        if (bi * B + j < pkt.size()) begin
          s_tdata[j*8 +: 8] = pkt[bi*B+j];
          s_tkeep[j]        = 1'b1;
        end
      end
      s_tlast  = close && (bi == nb - 1);
      s_tvalid = 1'b1;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 1000) begin
        @(negedge aclk);
        acc = s_tready;
        @(posedge aclk);
        #1;
        t++;
      end
      if (!acc) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
  endtask

  task automatic ramp_pkt(input int len, output u8_t pkt[$]);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(u8_t'(i));
  endtask

  task automatic run_vec(input vec_t v);
    u8_t pkt[$];
    beats = 0; seg_cnt = 0; short_cnt = 0; rdy_low = 0;
    ramp_pkt(v.len, pkt);
    push_expect(pkt);
    win = 1'b1;
    send_pkt(pkt, 0, 1'b1);
    repeat (4) @(posedge aclk);
    #1;
    win = 1'b0;
    check($sformatf("len%0d_beats", v.len), beats, v.beats);
    check($sformatf("len%0d_last_keep", v.len), last_keep, v.last_keep);
    check($sformatf("len%0d_seg_pulses", v.len), seg_cnt, v.segs);
    check($sformatf("len%0d_short_pulses", v.len), short_cnt, v.shorts);
    check($sformatf("len%0d_drain_cycles", v.len), rdy_low, v.drains);
    check($sformatf("len%0d_pkts_pending", v.len), exp_len_q.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    u8_t  pkt[$];
    int   t;

    //        len beats keep  seg short drain
    vecs[0] = '{24, 3, 8'h0F, 1, 0, 1};
    vecs[1] = '{20, 2, 8'hFF, 1, 0, 0};
    vecs[2] = '{16, 2, 8'h0F, 1, 0, 0};
    vecs[3] = '{14, 2, 8'h3F, 0, 1, 0};
    vecs[4] = '{ 8, 1, 8'hFF, 0, 1, 0};
    vecs[5] = '{ 3, 1, 8'h07, 0, 1, 0};
    vecs[6] = '{32, 4, 8'h0F, 1, 0, 1};
    vecs[7] = '{28, 3, 8'hFF, 1, 0, 0};
    vecs[8] = '{26, 3, 8'h3F, 1, 0, 0};
    vecs[9] = '{15, 2, 8'h7F, 0, 1, 0};

    aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    m_tready = 1'b1; win = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tkeep_tlast", {m_tkeep, m_tlast}, 0);
    check("rst_pulses", {seg_valid, short_pkt}, 0);
    check("rst_seg_data", seg_data, 0);
    check("rst_s_tready", s_tready, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("post_rst_s_tready", s_tready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // One-cycle latency: short packet output and pulse right after the accepting edge.
    ramp_pkt(8, pkt);
    push_expect(pkt);
    send_pkt(pkt, 0, 1'b1);
    check("lat_m_tvalid", m_tvalid, 1);
    check("lat_m_tdata", m_tdata, 64'h0706050403020100);
    check("lat_short_pkt", short_pkt, 1);
    repeat (3) @(posedge aclk);
    #1;

    // Stall: the held beat must not change and input must be refused.
    ready_mode = 2;
    @(posedge aclk);
    #1;
    ramp_pkt(8, pkt);
    push_expect(pkt);
    send_pkt(pkt, 0, 1'b1);
    repeat (3) @(posedge aclk);
    #1;
    check("stall_m_tvalid", m_tvalid, 1);
    check("stall_s_tready", s_tready, 0);
    check("stall_m_tdata", m_tdata, 64'h0706050403020100);
    ready_mode = 0;
    repeat (3) @(posedge aclk);
    #1;
    check("stall_released", exp_len_q.size(), 0);

    // Reset in BODY: the partial packet is dropped and the next one starts fresh.
    ramp_pkt(16, pkt);
    exp_seg_q.push_back(32'h0F0E0D0C);
    send_pkt(pkt, 0, 1'b0);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_m_tdata", m_tdata, 0);
    check("midrst_m_tkeep", m_tkeep, 0);
    check("midrst_s_tready", s_tready, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    run_vec(vecs[0]);

    // Back-to-back random packets with random gaps and random backpressure.
    short_cnt  = 0;
    ready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(256, 16);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(u8_t'($urandom_range(255)));
      push_expect(pkt);
      send_pkt(pkt, 20, 1'b1);
    end
    ready_mode = 0;
    t = 0;
    while (exp_len_q.size() != 0 && t < 500) begin
      @(posedge aclk);
      t++;
    end
    #1;
    check("rand_pkts_pending", exp_len_q.size(), 0);
    check("rand_segs_pending", exp_seg_q.size(), 0);
    check("rand_short_pulses", short_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
